// File: rtl/mpaddsub_limb.sv
// Limb-serial multi-precision adder/subtractor with conditional subtract.
// One LIMB-bit slice per CALC cycle through a registered carry/borrow.
module mpaddsub_limb #(
   parameter int WIDTH = 514,
   parameter int LIMB  = 64
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH:0]   result,
   output logic             done,
   output logic             busy
);

   localparam int NLIMB = (WIDTH + LIMB) / LIMB;
   localparam int P     = NLIMB * LIMB;
   localparam int CW    = $clog2(NLIMB + 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIN
   } state_t;

   state_t           state;
   logic [P-1:0]     a_q;
   logic [P-1:0]     b_q;
   logic [P-1:0]     sum_q;
   logic [WIDTH-1:0] a_keep;
   logic [1:0]       mode_q;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic [P-1:0]      a_ext;
   logic [P-1:0]      b_ext;
   logic              sub_req;
   logic [LIMB:0]     limb_sum;
   logic [P+LIMB-1:0] sum_sh;
   logic [WIDTH:0]    fin_val;
   logic              unused_bits;

   always_comb begin
      a_ext   = {{(P-WIDTH){1'b0}}, in_a};
      b_ext   = {{(P-WIDTH){1'b0}}, in_b};
      sub_req = (mode == 2'b01) || (mode == 2'b10);
   end

   always_comb begin
      limb_sum = {1'b0, a_q[LIMB-1:0]}
               + {1'b0, b_q[LIMB-1:0]}
               + {{LIMB{1'b0}}, carry};
      sum_sh   = {limb_sum[LIMB-1:0], sum_q} >> LIMB;
   end

   // A negative difference in conditional-subtract mode keeps a unchanged.
   always_comb begin
      fin_val = sum_q[WIDTH:0];
      if (mode_q == 2'b10 && sum_q[WIDTH])
         fin_val = {1'b0, a_keep};
   end

   assign unused_bits = ^{sum_sh[P+LIMB-1:P], sum_q};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         sum_q  <= '0;
         a_keep <= '0;
         mode_q <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         result <= '0;
         done   <= 1'b0;
         busy   <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               // The done cycle is still part of the operation.
               if (start && !done) begin
                  a_q    <= a_ext;
                  b_q    <= sub_req ? ~b_ext : b_ext;
                  carry  <= sub_req;
                  mode_q <= mode;
                  a_keep <= in_a;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= CALC;
               end
            end
            CALC: begin
               a_q   <= a_q >> LIMB;
               b_q   <= b_q >> LIMB;
               sum_q <= sum_sh[P-1:0];
               carry <= limb_sum[LIMB];
               cnt   <= cnt + 1'b1;
               if (cnt == CW'(NLIMB - 1))
                  state <= FIN;
            end
            FIN: begin
               result <= fin_val;
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mpaddsub_limb.sv
// Bench for mpaddsub_limb: three geometries (9, 4 and 1 limbs) share one
// stimulus stream and are checked every cycle against an arithmetic model.
module tb_mpaddsub_limb;

   typedef struct {
      logic [514:0] val;
      int           at;
   } op_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic start = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [513:0] a = '0;
   logic [513:0] b = '0;

   logic [514:0] r0;
   logic [100:0] r1;
   logic [63:0]  r2;
   logic [2:0]   dn;
   logic [2:0]   bz;
   logic [514:0] res [3];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int lat [3] = '{10, 5, 2};
   int wid [3] = '{514, 100, 63};
   int next_ok [3] = '{0, 0, 0};
   logic [514:0] last [3];
   op_t q [3][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mpaddsub_limb u0 (
      .clk(clk), .resetn(resetn), .start(start), .mode(mode),
      .in_a(a), .in_b(b), .result(r0), .done(dn[0]), .busy(bz[0])
   );
   mpaddsub_limb #(.WIDTH(100), .LIMB(32)) u1 (
      .clk(clk), .resetn(resetn), .start(start), .mode(mode),
      .in_a(a[99:0]), .in_b(b[99:0]), .result(r1),
      .done(dn[1]), .busy(bz[1])
   );
   mpaddsub_limb #(.WIDTH(63), .LIMB(64)) u2 (
      .clk(clk), .resetn(resetn), .start(start), .mode(mode),
      .in_a(a[62:0]), .in_b(b[62:0]), .result(r2),
      .done(dn[2]), .busy(bz[2])
   );

   assign res[0] = r0;
   assign res[1] = {414'd0, r1};
   assign res[2] = {451'd0, r2};

   function automatic logic [514:0] model(input logic [513:0] x,
                                          input logic [513:0] y,
                                          input logic [1:0] m,
                                          input int w);
      logic [514:0] mk, xm, ym, r;
      mk = (515'd1 << w) - 515'd1;
      xm = {1'b0, x} & mk;
      ym = {1'b0, y} & mk;
      case (m)
         2'b01:   r = (xm - ym) & ((mk << 1) | 515'd1);
         2'b10:   r = (xm >= ym) ? xm - ym : xm;
         default: r = xm + ym;
      endcase
      return r;
   endfunction

   function automatic logic [513:0] rnd();
      logic [543:0] t;
      for (int i = 0; i < 17; i++) t[i*32 +: 32] = $urandom();
      return t[513:0];
   endfunction

   task automatic chk(input string nm, input logic [514:0] act,
                      input logic [514:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%b exp=%b cyc=%0d", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (resetn) begin
         for (int k = 0; k < 3; k++) begin
            logic ed, eb;
            ed = q[k].size() > 0 && q[k][0].at == cyc;
            eb = q[k].size() > 0 && cyc >= q[k][0].at - lat[k]
                 && cyc < q[k][0].at;
            if (ed) begin
               last[k] = q[k][0].val;
               void'(q[k].pop_front());
            end
            chk1($sformatf("done%0d", k), dn[k], ed);
            chk1($sformatf("busy%0d", k), bz[k], eb);
            chk($sformatf("result%0d", k), res[k], last[k]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic [513:0] x, input logic [513:0] y,
                        input logic [1:0] m);
      int e;
      a = x;
      b = y;
      mode = m;
      start = 1'b1;
      e = cyc + 1;
      for (int k = 0; k < 3; k++) begin
         if (e >= next_ok[k]) begin
            q[k].push_back('{model(x, y, m, wid[k]), e + lat[k]});
            next_ok[k] = e + lat[k] + 2;
         end
      end
      step();
      start = 1'b0;
      a = rnd();
      b = rnd();
      mode = 2'($urandom());
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((q[0].size() + q[1].size() + q[2].size()) > 0 && n < 40) begin
         step();
         n++;
      end
      checks++;
      if (n >= 40) begin
         failures++;
         $display("FAIL idle_timeout act=busy exp=idle");
         for (int k = 0; k < 3; k++) q[k].delete();
      end
   endtask

   task automatic run(input logic [513:0] x, input logic [513:0] y,
                      input logic [1:0] m);
      drive(x, y, m);
      wait_idle();
      step();
   endtask

   logic [514:0] lit;
   logic [513:0] ones;

   initial begin
      for (int k = 0; k < 3; k++) last[k] = '0;
      ones = '1;
      step();
      chk("reset_r0", r0, '0);
      chk1("reset_done", dn[0], 1'b0);
      chk1("reset_busy", bz[0], 1'b0);
      resetn = 1'b1;
      step();

      run(514'd1, 514'd1, 2'b00);
      chk("add_1_1", r0, 515'h2);
      run(ones, 514'd1, 2'b00);
      lit = '0;
      lit[514] = 1'b1;
      chk("add_max_1", r0, lit);
      chk("add_max_1_w100", res[1], 515'd1 << 100);
      run(514'd1, 514'd1, 2'b01);
      chk("sub_1_1", r0, '0);
      run(514'd0, 514'd1, 2'b01);
      lit = '1;
      chk("sub_0_1", r0, lit);
      chk("sub_0_1_w63", {451'd0, r2}, {451'd0, 64'hFFFF_FFFF_FFFF_FFFF});
      run(514'd100, 514'd37, 2'b10);
      chk("csub_100_37", r0, 515'd63);
      run(514'd37, 514'd100, 2'b10);
      chk("csub_37_100", r0, 515'd37);
      chk("csub_37_100_w100", res[1], 515'd37);
      run(514'd5, 514'd5, 2'b10);
      chk("csub_5_5", r0, '0);
      run(514'd7, 514'd9, 2'b11);
      chk("mode11_add", r0, 515'd16);

      // second start while busy must be ignored by every geometry
      drive(514'd1000, 514'd24, 2'b00);
      step();
      step();
      drive(514'd5, 514'd3, 2'b01);
      wait_idle();
      step();
      chk("ignored_start", r0, 515'd1024);

      // start held into the done cycle, then a back-to-back accept
      drive(514'd2, 514'd3, 2'b00);
      wait_idle();
      run(514'd40, 514'd2, 2'b01);
      chk("after_done", r0, 515'd38);

      // reset mid-CALC abandons the operation
      drive(ones, ones, 2'b00);
      step();
      step();
      step();
      resetn = 1'b0;
      for (int k = 0; k < 3; k++) begin
         q[k].delete();
         next_ok[k] = 0;
         last[k] = '0;
      end
      step();
      chk("rst_r0", r0, '0);
      chk("rst_r1", res[1], '0);
      chk1("rst_done", dn[0], 1'b0);
      resetn = 1'b1;
      step();
      run(514'd12, 514'd30, 2'b01);
      lit = '1;
      lit[4:0] = 5'b01110;
      chk("post_rst_sub", r0, lit);

      for (int i = 0; i < 16; i++) begin
         logic [513:0] x, y;
         x = rnd();
         y = (i % 5 == 4) ? x : rnd();
         if (i % 3 == 0) y = ~x;
         run(x, y, 2'(i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mpaddsub_limb.md
Name: mpaddsub_limb

Overview:
Parametrised multi-precision adder/subtractor, successor to the fixed 514-bit mpadder. It processes one LIMB-bit slice per clock with a registered carry/borrow chain, so the critical path is limb-wide rather than operand-wide. It adds a conditional-subtract mode (a-b if a>=b, else a) for the final reduction step of the Montgomery datapath. It keeps the start/done handshake of the existing arithmetic blocks.

Parameters:
WIDTH, 514, operand width in bits; result is WIDTH+1 bits.
LIMB, 64, bits processed per CALC cycle; legal range 1..WIDTH+1.
NLIMB, ceil((WIDTH+1)/LIMB), derived localparam; padded width P = NLIMB*LIMB >= WIDTH+1.

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
mode  input  2  00 add, 01 subtract, 10 conditional subtract, 11 treated as add
in_a  input  WIDTH  operand A, sampled with start
in_b  input  WIDTH  operand B, sampled with start
result  output  WIDTH+1  registered result
done  output  1  one-cycle pulse, result valid
busy  output  1  high while an operation is in flight (CALC, FIN)

Behaviour:
- Reset (asynchronous, any state): state=IDLE; result=0, done=0, busy=0; all operand/shift/counter/carry regs=0. An in-flight operation is abandoned and produces no done.
- States: IDLE, CALC, FIN.
- IDLE, start=1: latch A zero-extended to P bits. Latch B zero-extended to P bits and bitwise-inverted if mode is 01 or 10. Set carry_in = 1 for sub modes, else 0. Latch mode, keep an unmodified copy of A for mode 10, clear limb counter, go to CALC. start=0: stay.
- CALC: each cycle compute {c, s} = A[LIMB-1:0] + B[LIMB-1:0] + carry. Shift s into the top of the sum register, shift A and B right by LIMB, carry<=c, counter++. After NLIMB cycles (counter==NLIMB-1), go to FIN.
- FIN: sum[WIDTH:0] is the (WIDTH+1)-bit two's-complement a+b or a-b. For add, result[WIDTH] is the carry. For sub, result[WIDTH] is the sign (1 when a<b).
- FIN, mode 10: if sum[WIDTH]==0 (a>=b), result=sum[WIDTH:0]; else result={1'b0,a}.
- FIN actions: load result, done=1 for exactly this cycle, go to IDLE.
- Latency: start sampled at edge 0. done is high in the cycle after edge NLIMB+1, and result is valid in that same cycle. Defaults: NLIMB=9, so 10 edges.
- result holds its value until the next FIN. It does not change on start.
- busy=1 in CALC and FIN, 0 in IDLE. start while busy is ignored, including in the done cycle. A new start is accepted on the cycle after done.
- in_a, in_b and mode may change freely after the accepting edge; they have no effect until the next accept.
- Carry out of bit P-1 is discarded. Zero-extension guarantees correct WIDTH+1 results for all operand values.
- A mode 11 request behaves exactly as mode 00.

Test Plan:
- Add 1+1, defaults -> result=515'h2; done pulses exactly one cycle, 10 edges after the start edge; busy high for 10 cycles.
- Add a=2^514-1, b=1 -> result=515'h1<<514. Subtract 1-1 -> 0. Subtract 0-1 -> all 515 bits 1 (sign set).
- Conditional subtract a=100, b=37 -> 63. Then a=37, b=100 -> 37. Then a=b=5 -> 0.
- Random add/sub vectors (same generator script as the mpadder bench) compared against a Python model; include operands with carries crossing every limb boundary.
- Pulse start again 3 cycles into an operation with different operands -> ignored; the first result is correct and a single done is produced. resetn low mid-CALC -> no done, result=0; the next operation is correct.
- Re-run with WIDTH=100, LIMB=32 (NLIMB=4, latency 5) and WIDTH=63, LIMB=64 (NLIMB=1, latency 2): add/sub/cond-sub corner cases pass.
